// File: rtl/zero_cross_freq_meter.sv
// zero_cross_freq_meter: pitch estimator counting hysteresis-qualified rising zero crossings per gate window
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset (priority over enable)
//   enable       run enable; low freezes every register and masks freq_valid
//   sample_valid qualifies sample for one cycle
//   sample       signed audio sample, SAMPLE_W bits
//   freq_out     measured frequency in Hz, 15 bits, stable between freq_valid pulses
//   freq_valid   one-cycle result strobe
//   sat_flag     last published result saturated
// Optional feature macro FREQ_AVG_EN: publish the mean of the last four window results.
module zero_cross_freq_meter #(
    parameter int SAMPLE_W    = 16,
    parameter int GATE_CYCLES = 25000000,
    parameter int GATE_SHIFT  = 2,
    parameter int HYST        = 256,
    parameter int MIN_HZ      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic [14:0]                freq_out,
    output logic                       freq_valid,
    output logic                       sat_flag
);
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int SW = 16 + GATE_SHIFT;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic signed [SAMPLE_W-1:0] HYST_P = SAMPLE_W'(HYST);
    localparam logic signed [SAMPLE_W-1:0] HYST_N = SAMPLE_W'(-HYST);

    typedef enum logic [1:0] {COUNT, SCALE, AVG, PUBLISH} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gate_q, gate_d;
    logic [15:0]   cross_cnt_q, cross_cnt_d;
    logic [15:0]   final_q, final_d;
    logic          armed_q, armed_d;
    logic [14:0]   freq_out_q, freq_out_d;
    logic          freq_valid_q, freq_valid_d;
    logic          sat_flag_q, sat_flag_d;
    logic          hit, gate_end, sat;
    logic [15:0]   cnt_inc;
    logic [SW-1:0] scaled;
    logic [14:0]   result;
`ifdef FREQ_AVG_EN
    logic [3:0][14:0] hist_q, hist_d;
    logic [3:0]       hsat_q, hsat_d;
    logic [16:0]      sum_q, sum_d;
    logic [2:0]       fill_q, fill_d;
`endif

    always_comb begin
        state_d      = state_q;
        gate_d       = gate_q;
        cross_cnt_d  = cross_cnt_q;
        final_d      = final_q;
        armed_d      = armed_q;
        freq_out_d   = freq_out_q;
        freq_valid_d = freq_valid_q;
        sat_flag_d   = sat_flag_q;
`ifdef FREQ_AVG_EN
        hist_d       = hist_q;
        hsat_d       = hsat_q;
        sum_d        = sum_q;
        fill_d       = fill_q;
`endif
        hit      = sample_valid && armed_q && sample >= HYST_P;
        cnt_inc  = (hit && cross_cnt_q != 16'hffff) ? cross_cnt_q + 16'd1 : cross_cnt_q;
        gate_end = gate_q == GATE_LAST;
        scaled   = SW'(final_q) << GATE_SHIFT;
        sat      = scaled > SW'(32767);
        result   = sat ? 15'h7fff : (scaled < SW'(MIN_HZ) ? 15'd0 : scaled[14:0]);
        if (enable) begin
            armed_d     = (sample_valid && sample <= HYST_N) ? 1'b1 : (hit ? 1'b0 : armed_q);
            gate_d      = gate_end ? '0 : gate_q + GW'(1);
            // a crossing on the gate-end cycle belongs to the ending window
            cross_cnt_d = gate_end ? 16'd0 : cnt_inc;
            final_d     = gate_end ? cnt_inc : final_q;
            case (state_q)
                COUNT: state_d = gate_end ? SCALE : COUNT;
`ifdef FREQ_AVG_EN
                SCALE: begin
                    hist_d  = {hist_q[2:0], result};
                    hsat_d  = {hsat_q[2:0], sat};
                    sum_d   = sum_q + 17'(result) - 17'(hist_q[3]);
                    fill_d  = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
                    state_d = AVG;
                end
                AVG: begin
                    freq_valid_d = fill_q == 3'd4;
                    freq_out_d   = (fill_q == 3'd4) ? sum_q[16:2] : freq_out_q;
                    sat_flag_d   = (fill_q == 3'd4) ? |hsat_q : sat_flag_q;
                    state_d      = (fill_q == 3'd4) ? PUBLISH : COUNT;
                end
`else
                SCALE: begin
                    freq_out_d   = result;
                    sat_flag_d   = sat;
                    freq_valid_d = 1'b1;
                    state_d      = PUBLISH;
                end
`endif
                PUBLISH: begin
                    freq_valid_d = 1'b0;
                    state_d      = COUNT;
                end
                default: state_d = COUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COUNT;
            gate_q       <= '0;
            cross_cnt_q  <= '0;
            final_q      <= '0;
            armed_q      <= 1'b0;
            freq_out_q   <= '0;
            freq_valid_q <= 1'b0;
            sat_flag_q   <= 1'b0;
`ifdef FREQ_AVG_EN
            hist_q       <= '0;
            hsat_q       <= '0;
            sum_q        <= '0;
            fill_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            gate_q       <= gate_d;
            cross_cnt_q  <= cross_cnt_d;
            final_q      <= final_d;
            armed_q      <= armed_d;
            freq_out_q   <= freq_out_d;
            freq_valid_q <= freq_valid_d;
            sat_flag_q   <= sat_flag_d;
`ifdef FREQ_AVG_EN
            hist_q       <= hist_d;
            hsat_q       <= hsat_d;
            sum_q        <= sum_d;
            fill_q       <= fill_d;
`endif
        end
    end

    // a pulse held over a disabled stretch is released on the first enabled cycle
    assign freq_valid = freq_valid_q && enable;
    assign freq_out   = freq_out_q;
    assign sat_flag   = sat_flag_q;
endmodule

// File: tb/tb_zero_cross_freq_meter.sv
// tb_zero_cross_freq_meter: directed bench with a window-level reference model
module tb_zero_cross_freq_meter;
    localparam int GATE = 1000, HYST = 100, MIN_HZ = 2;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, sample_valid = 1'b1;
    logic signed [15:0] sample = '0;
    logic [14:0] fo0, fo1;
    logic fv0, fv1, sf0, sf1;

    zero_cross_freq_meter #(.SAMPLE_W(16), .GATE_CYCLES(GATE), .GATE_SHIFT(0), .HYST(HYST), .MIN_HZ(MIN_HZ)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid), .sample(sample),
        .freq_out(fo0), .freq_valid(fv0), .sat_flag(sf0));
    zero_cross_freq_meter #(.SAMPLE_W(16), .GATE_CYCLES(GATE), .GATE_SHIFT(12), .HYST(HYST), .MIN_HZ(MIN_HZ)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid), .sample(sample),
        .freq_out(fo1), .freq_valid(fv1), .sat_flag(sf1));

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    bit started = 0;
    int pt[$], pv0[$], pv1[$], ps1[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // window-level reference: count crossings per GATE enabled cycles, publish after the pipeline delay
    int e, g, cnt, due, a, b, pv0m, ps0m, pv1m, ps1m, eo0, es0, eo1, es1;
    bit arm, ev, pend;
    int q0[$], q1[$], qs0[$], qs1[$];

    function automatic void res(int c, int sh, output int v, output int s);
        longint x = longint'(c) << sh;
        s = (x > 32767) ? 1 : 0;
        v = s ? 32767 : (x < MIN_HZ ? 0 : int'(x));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            e = 0; g = 0; cnt = 0; arm = 0; ev = 0; pend = 0;
            eo0 = 0; es0 = 0; eo1 = 0; es1 = 0;
            q0.delete(); q1.delete(); qs0.delete(); qs1.delete();
        end else if (enable) begin
            e++;
            ev = 0;
            if (sample_valid) begin
                if (sample <= -HYST) arm = 1;
                else if (arm && sample >= HYST) begin
                    arm = 0;
                    if (cnt < 65535) cnt++;
                end
            end
            if (pend && e == due) begin
                ev = 1; eo0 = pv0m; es0 = ps0m; eo1 = pv1m; es1 = ps1m; pend = 0;
            end
            g++;
            if (g == GATE) begin
`ifdef FREQ_AVG_EN
                res(cnt, 0, a, b); q0.push_back(a); qs0.push_back(b);
                res(cnt, 12, a, b); q1.push_back(a); qs1.push_back(b);
                if (q0.size() > 4) begin
                    void'(q0.pop_front()); void'(qs0.pop_front());
                    void'(q1.pop_front()); void'(qs1.pop_front());
                end
                if (q0.size() == 4) begin
                    pv0m = q0.sum() >> 2; ps0m = (qs0.sum() != 0) ? 1 : 0;
                    pv1m = q1.sum() >> 2; ps1m = (qs1.sum() != 0) ? 1 : 0;
                    pend = 1; due = e + 2;
                end
`else
                res(cnt, 0, pv0m, ps0m);
                res(cnt, 12, pv1m, ps1m);
                pend = 1; due = e + 1;
`endif
                g = 0; cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("valid0", fv0, ev && enable);
            chk("out0", fo0, eo0);
            chk("sat0", sf0, es0);
            chk("valid1", fv1, ev && enable);
            chk("out1", fo1, eo1);
            chk("sat1", sf1, es1);
        end
    end

    task automatic step(int s, bit en);
        sample = 16'(s);
        enable = en;
        @(posedge clk);
        #1;
        cyc++;
        if (fv0) begin
            pt.push_back(cyc); pv0.push_back(int'(fo0)); pv1.push_back(int'(fo1)); ps1.push_back(int'(sf1));
        end
    endtask

    task automatic release_rst();
        rst = 0; cyc = 0;
        pt.delete(); pv0.delete(); pv1.delete(); ps1.delete();
    endtask

    task automatic reset_dut();
        rst = 1;
        step(0, 1);
        step(0, 1);
        chk("rst_out0", fo0, 0);
        chk("rst_valid0", fv0, 0);
        chk("rst_sat1", sf1, 0);
        release_rst();
        started = 1;
    endtask

    // mode 0 square, 1 square with in-band noise at transitions, 2 in-band square,
    // 3 single crossing on the last window cycle, 4 crossings at 100, 300 and 999
    function automatic int wav(int mode, int n, int i);
        int st = 1000 / n;
        int p = i % st;
        int h = st / 2;
        if (mode == 3) return (i == 999) ? 1000 : -1000;
        if (mode == 4) return (i == 100 || i == 300 || i == 999) ? 1000 : -1000;
        if (mode == 1 && ((p >= h - 5 && p < h) || p >= st - 5)) return (i % 2 == 1) ? 60 : -60;
        if (mode == 2) return (p >= h) ? 50 : -50;
        return (p >= h) ? 1000 : -1000;
    endfunction

    task automatic win(int mode, int n, int from, int to);
        for (int i = from; i <= to; i++) step(wav(mode, n, i), 1);
    endtask

    task automatic exp_pulse(string nm, int idx, int t, int v0, int v1, int s1);
        chk({nm, "_seen"}, (pt.size() > idx) ? 1 : 0, 1);
        if (pt.size() > idx) begin
            chk({nm, "_time"}, pt[idx], t);
            chk({nm, "_val0"}, pv0[idx], v0);
            chk({nm, "_val1"}, pv1[idx], v1);
            chk({nm, "_sat1"}, ps1[idx], s1);
        end
    endtask

    initial begin
        reset_dut();
`ifdef FREQ_AVG_EN
        win(0, 10, 0, 999); win(0, 20, 0, 999); win(0, 30, 0, 999); win(0, 40, 0, 999); win(0, 10, 0, 9);
        chk("avg_npulse", pt.size(), 1);
        exp_pulse("avg", 0, 4002, 25, 32767, 1);
`else
        win(0, 10, 0, 999); win(0, 10, 0, 999); win(0, 5, 0, 999); win(0, 5, 0, 9);
        chk("sq_npulse", pt.size(), 3);
        exp_pulse("sq_w1", 0, 1001, 10, 32767, 1);
        exp_pulse("sq_w2", 1, 2001, 10, 32767, 1);
        exp_pulse("sq_w3", 2, 3001, 5, 20480, 0);

        reset_dut();
        win(2, 10, 0, 999); win(2, 10, 0, 999); win(2, 10, 0, 9);
        chk("hyst_npulse", pt.size(), 2);
        exp_pulse("hyst_w1", 0, 1001, 0, 0, 0);
        exp_pulse("hyst_w2", 1, 2001, 0, 0, 0);

        reset_dut();
        win(1, 10, 0, 999); win(1, 10, 0, 999); win(1, 10, 0, 9);
        exp_pulse("noise_w1", 0, 1001, 10, 32767, 1);
        exp_pulse("noise_w2", 1, 2001, 10, 32767, 1);

        reset_dut();
        win(3, 10, 0, 999); win(4, 10, 0, 999); win(0, 10, 0, 9);
        exp_pulse("edge_w1", 0, 1001, 0, 4096, 0);
        exp_pulse("edge_w2", 1, 2001, 3, 12288, 0);

        reset_dut();
        win(0, 10, 0, 999); win(0, 10, 0, 499);
        chk("mid_before", fo0, 10);
        rst = 1;
        step(-1000, 1);
        chk("mid_rst_out", fo0, 0);
        release_rst();
        win(0, 10, 0, 999); win(0, 10, 0, 9);
        chk("mid_npulse", pt.size(), 1);
        exp_pulse("mid", 0, 1001, 10, 32767, 1);

        reset_dut();
        win(0, 10, 0, 299);
        for (int i = 0; i < 200; i++) step(1000, 0);
        win(0, 10, 300, 999); win(0, 10, 0, 9);
        chk("en_npulse", pt.size(), 1);
        exp_pulse("en", 0, 1201, 10, 32767, 1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
